// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared constants for the decode-stage forwarding/hazard scoreboard.
package id_fwd_scoreboard_pkg;

  // Architectural register index width.
  localparam int unsigned REG_INDEX_BUS = 5;

  // Tracked stage positions after decode.
  localparam int unsigned STAGE_ID2EX  = 0;
  localparam int unsigned STAGE_EX2MEM = 1;
  localparam int unsigned STAGE_MEM2WB = 2;

  // Default ready-stage encodings: ALU results are valid out of id2ex, loads out of ex2mem.
  localparam int unsigned RDY_ALU  = STAGE_ID2EX;
  localparam int unsigned RDY_LOAD = STAGE_EX2MEM;

endpackage

// File: rtl/id_fwd_sb_port.sv
// One read port: youngest-match search over in-flight entries, operand mux and hazard bit.
module id_fwd_sb_port
  import id_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RSW   = 2
) (
  input  logic                       rs_en_i,
  input  logic [REG_INDEX_BUS-1:0]   rs_index_i,
  input  logic [XLEN-1:0]            rf_data_i,
  input  logic [DEPTH*XLEN-1:0]      stage_data_i,
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [DEPTH*REG_INDEX_BUS-1:0] rd_i,
  input  logic [DEPTH*RSW-1:0]       rdy_i,
  output logic [XLEN-1:0]            data_c,
  output logic                       hazard_c
);

  logic found;

  // Lowest matching stage wins; a matured match forwards, an immature one flags a hazard.
  always_comb begin
    found    = 1'b0;
    data_c   = rf_data_i;
    hazard_c = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!found && rs_en_i && (rs_index_i != '0) && valid_i[k] &&
          (rd_i[k*REG_INDEX_BUS +: REG_INDEX_BUS] == rs_index_i)) begin
        found = 1'b1;
        if (rdy_i[k*RSW +: RSW] <= RSW'(k)) begin
          data_c = stage_data_i[k*XLEN +: XLEN];
        end else begin
          hazard_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage operand forwarding and hazard scoreboard.
// Optional stall-cycle counter enabled by defining ID_FWD_SB_PERF_EN.
module id_fwd_scoreboard
  import id_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned RSW      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         advance_i,
  input  logic                         issue_valid_i,
  input  logic                         issue_rd_en_i,
  input  logic [REG_INDEX_BUS-1:0]     issue_rd_index_i,
  input  logic [RSW-1:0]               issue_ready_stage_i,
  input  logic [RD_PORTS-1:0]          rs_en_i,
  input  logic [RD_PORTS*REG_INDEX_BUS-1:0] rs_index_i,
  input  logic [RD_PORTS*XLEN-1:0]     rf_data_i,
  input  logic [DEPTH*XLEN-1:0]        stage_data_i,
  output logic [RD_PORTS*XLEN-1:0]     rs_data_o,
  output logic                         stall_o
`ifdef ID_FWD_SB_PERF_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  logic [DEPTH-1:0]               valid_q, valid_d;
  logic [DEPTH*REG_INDEX_BUS-1:0] rd_q, rd_d;
  logic [DEPTH*RSW-1:0]           rdy_q, rdy_d;
  logic [RD_PORTS-1:0]            hazard;

  // Per-port resolution against the current entries.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    id_fwd_sb_port #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN),
      .RSW   (RSW)
    ) u_port (
      .rs_en_i      (rs_en_i[p]),
      .rs_index_i   (rs_index_i[p*REG_INDEX_BUS +: REG_INDEX_BUS]),
      .rf_data_i    (rf_data_i[p*XLEN +: XLEN]),
      .stage_data_i (stage_data_i),
      .valid_i      (valid_q),
      .rd_i         (rd_q),
      .rdy_i        (rdy_q),
      .data_c       (rs_data_o[p*XLEN +: XLEN]),
      .hazard_c     (hazard[p])
    );
  end

  assign stall_o = issue_valid_i & (|hazard);

  // Shift entries one stage on advance; a stalled issue enters as a bubble.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    rdy_d   = rdy_q;
    if (advance_i) begin
      valid_d = {valid_q[DEPTH-2:0],
                 issue_valid_i & issue_rd_en_i & (issue_rd_index_i != '0) & ~stall_o};
      rd_d    = {rd_q[(DEPTH-1)*REG_INDEX_BUS-1:0], issue_rd_index_i};
      rdy_d   = {rdy_q[(DEPTH-1)*RSW-1:0], issue_ready_stage_i};
    end
  end

  // Entry state register; reset drops all in-flight tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      rd_q    <= '0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef ID_FWD_SB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles that inserted a bubble.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && advance_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
